// File: rtl/add_acc_pkg.sv
// Shared definitions for the add_accumulator stage: FSM encoding and default widths.
package add_acc_pkg;

  localparam int unsigned ACC_N_DEF     = 8;
  localparam int unsigned ACC_CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } acc_state_e;

endpackage

// File: rtl/ripple_adder_n.sv
// N-bit ripple-carry adder built from chained full-adder cells; purely combinational.
module ripple_adder_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[N];

endmodule

// File: rtl/add_accumulator.sv
// Packet accumulation stage: sums a valid/ready operand stream and presents
// sum, sticky carry and saturating beat count as one back-pressurable result beat.
module add_accumulator
  import add_acc_pkg::*;
#(
  parameter int N     = ACC_N_DEF,
  parameter int CNT_W = ACC_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic             out_carry,
  output logic [CNT_W-1:0] out_count
);

  acc_state_e       state_q, state_d;
  logic [N-1:0]     acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             init_q;

  logic [N-1:0]     add_sum;
  logic             add_cout;
  logic             hold;
  logic             accept;

  ripple_adder_n #(.N(N)) u_adder (
    .a    (acc_q),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign hold   = (state_q == HOLD);
  // init_q keeps in_ready low until the first clock after reset release
  assign in_ready = init_q & ~hold;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = in_data;
          carry_d = 1'b0;
          count_d = CNT_W'(1);
          state_d = in_last ? HOLD : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          acc_d   = add_sum;
          carry_d = carry_q | add_cout;
          count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);
          if (in_last) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          carry_d = 1'b0;
          count_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        acc_d   = '0;
        carry_d = 1'b0;
        count_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      count_q <= count_d;
      init_q  <= 1'b1;
    end
  end

  // Outputs are forced to zero outside HOLD so monitors can sample freely
  assign out_valid = hold;
  assign out_sum   = hold ? acc_q : '0;
  assign out_carry = hold & carry_q;
  assign out_count = hold ? count_q : '0;

endmodule

// File: tb/tb_add_accumulator.sv
// Self-checking bench for add_accumulator: vector table, corner sequences, random packets.
module tb_add_accumulator;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_carry;
  logic [3:0] out_count;

  int n_checks = 0;
  int n_fail   = 0;

  add_accumulator #(.N(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d [4];
    int         n;
    logic [7:0] esum;
    logic       ecarry;
    logic [3:0] ecount;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: integer total of the packet; any wrap of the running sum means total >= 2**N
  task automatic model(input logic [7:0] q[$], output logic [7:0] s, output logic c,
                       output logic [3:0] k);
    int total = 0;
    foreach (q[i]) total += int'(q[i]);
    s = total[7:0];
    c = (total >= 256);
    k = (q.size() > 15) ? 4'd15 : 4'(q.size());
  endtask

  // Called at a negedge; returns at the negedge after the beat's handshake
  task automatic drive_beat(input logic [7:0] d, input logic l);
    int unsigned t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic run_packet(input logic [7:0] q[$], input bit rnd, input logic [7:0] esum,
                            input logic ecarry, input logic [3:0] ecount);
    int unsigned hold_cyc;
    int unsigned t = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (rnd && $urandom_range(0, 3) == 0) @(negedge clk);
      drive_beat(q[i], i == q.size() - 1);
      if (i != q.size() - 1) begin
        chk("mid_pkt_valid", out_valid, 0);
        chk("mid_pkt_sum_zero", out_sum, 0);
      end
    end
    chk("latency_valid", out_valid, 1);
    chk("sum", out_sum, esum);
    chk("carry", out_carry, ecarry);
    chk("count", out_count, ecount);
    hold_cyc = rnd ? $urandom_range(0, 3) : 0;
    repeat (hold_cyc) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_sum", out_sum, esum);
      chk("hold_count", out_count, ecount);
    end
    out_ready = 1'b1;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    out_ready = 1'b0;
    chk("retired_valid", out_valid, 0);
    chk("idle_sum", out_sum, 0);
    chk("idle_count", out_count, 0);
    chk("idle_in_ready", in_ready, 1);
  endtask

  initial begin
    vec_t        vt [6];
    logic [7:0]  q [$];
    logic [7:0]  ms;
    logic        mc;
    logic [3:0]  mk;

    vt[0] = '{d: '{8'h10, 8'h20, 8'h03, 8'h00}, n: 3, esum: 8'h33, ecarry: 1'b0, ecount: 4'd3};
    vt[1] = '{d: '{8'hF0, 8'h20, 8'h00, 8'h00}, n: 2, esum: 8'h10, ecarry: 1'b1, ecount: 4'd2};
    vt[2] = '{d: '{8'hAB, 8'h00, 8'h00, 8'h00}, n: 1, esum: 8'hAB, ecarry: 1'b0, ecount: 4'd1};
    vt[3] = '{d: '{8'hFF, 8'h01, 8'h00, 8'h00}, n: 2, esum: 8'h00, ecarry: 1'b1, ecount: 4'd2};
    vt[4] = '{d: '{8'h80, 8'h80, 8'h80, 8'h80}, n: 4, esum: 8'h00, ecarry: 1'b1, ecount: 4'd4};
    vt[5] = '{d: '{8'h7F, 8'h80, 8'h00, 8'h00}, n: 2, esum: 8'hFF, ecarry: 1'b0, ecount: 4'd2};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_carry", out_carry, 0);
    chk("rst_out_count", out_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_in_ready", in_ready, 1);

    foreach (vt[v]) begin
      q = {};
      for (int i = 0; i < vt[v].n; i++) q.push_back(vt[v].d[i]);
      run_packet(q, 1'b0, vt[v].esum, vt[v].ecarry, vt[v].ecount);
    end

    // Backpressure: held result stays put and a pending operand is not consumed
    drive_beat(8'h11, 1'b0);
    drive_beat(8'h22, 1'b1);
    in_valid = 1'b1; in_data = 8'h55; in_last = 1'b1;
    repeat (5) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_sum", out_sum, 8'h33);
      chk("bp_count", out_count, 2);
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    chk("bp_retire_in_ready", in_ready, 0);
    @(negedge clk);
    out_ready = 1'b0;
    run_packet('{8'h01}, 1'b0, 8'h01, 1'b0, 4'd1);

    // Saturation of the beat counter
    q = {};
    repeat (20) q.push_back(8'h01);
    run_packet(q, 1'b0, 8'h14, 1'b0, 4'd15);

    // Reset mid-packet discards partial state
    drive_beat(8'h07, 1'b0);
    drive_beat(8'h08, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("midrst_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 1);
    run_packet('{8'h02}, 1'b0, 8'h02, 1'b0, 4'd1);

    // Asynchronous reset while a result is held clears outputs before any clock edge
    drive_beat(8'h40, 1'b1);
    chk("hold_before_rst", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_sum", out_sum, 0);
    chk("async_rst_count", out_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Random packets against the reference model
    for (int p = 0; p < 40; p++) begin
      int unsigned len = $urandom_range(1, 20);
      q = {};
      for (int i = 0; i < int'(len); i++) q.push_back(8'($urandom));
      model(q, ms, mc, mk);
      run_packet(q, 1'b1, ms, mc, mk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
